// File: rtl/residue_channel_arbiter_if.sv
// rtl/residue_channel_arbiter_if.sv - handshake bundle between two residue requesters, the arbiter and downstream
interface residue_channel_arbiter_if;
   logic       a_valid;
   logic [5:0] a_data;
   logic       a_ready;
   logic       b_valid;
   logic [5:0] b_data;
   logic       b_ready;
   logic       out_valid;
   logic [5:0] out_data;
   logic       out_src;
   logic       out_ready;

   modport master (
      output a_valid, a_data, b_valid, b_data, out_ready,
      input  a_ready, b_ready, out_valid, out_data, out_src
   );

   modport slave (
      input  a_valid, a_data, b_valid, b_data, out_ready,
      output a_ready, b_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/residue_channel_arbiter.sv
// rtl/residue_channel_arbiter.sv - two-requester burst-limited arbiter onto one registered 6-bit residue channel
module residue_channel_arbiter #(
   parameter int MAX_BURST = 4
) (
   input logic                     clk,
   input logic                     reset_n,
   residue_channel_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   state_t     state;
   logic [3:0] burst_cnt;
   logic [3:0] burst_inc;
   logic       under_limit;
   logic       stage_free;
   logic       grant_a;
   logic       grant_b;
   logic [5:0] sel_data;
   logic       out_valid_q;
   logic [5:0] out_data_q;
   logic       out_src_q;

   assign stage_free  = !out_valid_q || bus.out_ready;
   assign under_limit = burst_cnt < BURST_LIMIT;
   assign burst_inc   = (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;

   // Grants depend only on state and valids, never on data; reset_n gates them off during reset.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (reset_n && stage_free) begin
         case (state)
            IDLE: begin
               if (bus.a_valid)      grant_a = 1'b1;
               else if (bus.b_valid) grant_b = 1'b1;
            end
            OWN_A: begin
               if (bus.a_valid && (!bus.b_valid || under_limit)) grant_a = 1'b1;
               else if (bus.b_valid)                            grant_b = 1'b1;
            end
            OWN_B: begin
               if (bus.b_valid && (!bus.a_valid || under_limit)) grant_b = 1'b1;
               else if (bus.a_valid)                            grant_a = 1'b1;
            end
            default: begin
               grant_a = 1'b0;
               grant_b = 1'b0;
            end
         endcase
      end
   end

   assign sel_data = grant_b ? bus.b_data : bus.a_data;

   assign bus.a_ready   = grant_a;
   assign bus.b_ready   = grant_b;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         burst_cnt   <= 4'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 6'd0;
         out_src_q   <= 1'b0;
      end else if (stage_free) begin
         if (grant_a) begin
            state       <= OWN_A;
            burst_cnt   <= (state == OWN_A) ? burst_inc : 4'd1;
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_src_q   <= 1'b0;
         end else if (grant_b) begin
            state       <= OWN_B;
            burst_cnt   <= (state == OWN_B) ? burst_inc : 4'd1;
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_src_q   <= 1'b1;
         end else begin
            state       <= IDLE;
            burst_cnt   <= 4'd0;
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_residue_channel_arbiter.sv
// tb/tb_residue_channel_arbiter.sv - directed and scoreboarded checks of residue_channel_arbiter
module tb_residue_channel_arbiter;
   localparam int MB = 4;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   residue_channel_arbiter_if bus ();

   residue_channel_arbiter #(.MAX_BURST(MB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic av, input logic [5:0] ad, input logic bv,
                        input logic [5:0] bd, input logic ordy);
      bus.a_valid   = av;
      bus.a_data    = ad;
      bus.b_valid   = bv;
      bus.b_data    = bd;
      bus.out_ready = ordy;
   endtask

   task automatic drain();
      @(negedge clk);
      drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(1'b1, 6'd3, 1'b1, 6'd4, 1'b1);
      @(posedge clk);
      #1;
      checks++;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_readies got a=%b b=%b want 0 0", bus.a_ready, bus.b_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 6'd0 || bus.out_src !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b d=%0d s=%b want 0 0 0", bus.out_valid, bus.out_data, bus.out_src);
      end
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_a();
      @(negedge clk);
      drive(1'b1, 6'd17, 1'b0, 6'd0, 1'b1);
      #1;
      checks++;
      if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_a_ready got a=%b b=%b want 1 0", bus.a_ready, bus.b_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 6'd17 || bus.out_src !== 1'b0) begin
         errors++;
         $display("FAIL single_a_out got v=%b d=%0d s=%b want 1 17 0", bus.out_valid, bus.out_data, bus.out_src);
      end
      drain();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_a_empty got v=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_alternation();
      logic exp_src;
      logic [5:0] exp_data;
      @(negedge clk);
      drive(1'b1, 6'd5, 1'b1, 6'd9, 1'b1);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         exp_src  = ((i / MB) % 2) == 1;
         exp_data = exp_src ? 6'd9 : 6'd5;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_src !== exp_src || bus.out_data !== exp_data) begin
            errors++;
            $display("FAIL alternation_beat%0d got v=%b s=%b d=%0d want 1 %b %0d", i,
                     bus.out_valid, bus.out_src, bus.out_data, exp_src, exp_data);
         end
      end
      drain();
   endtask

   task automatic test_stall();
      @(negedge clk);
      drive(1'b1, 6'd42, 1'b0, 6'd0, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 6'd42) begin
         errors++;
         $display("FAIL stall_load got v=%b d=%0d want 1 42", bus.out_valid, bus.out_data);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(1'b1, 6'd50, 1'b1, 6'd51, 1'b0);
         #1;
         checks++;
         if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready%0d got a=%b b=%b want 0 0", i, bus.a_ready, bus.b_ready);
         end
         @(posedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 6'd42 || bus.out_src !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d got v=%b d=%0d s=%b want 1 42 0", i,
                     bus.out_valid, bus.out_data, bus.out_src);
         end
      end
      @(negedge clk);
      drive(1'b1, 6'd43, 1'b1, 6'd51, 1'b1);
      #1;
      checks++;
      if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_release got a=%b b=%b want 1 0", bus.a_ready, bus.b_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_data !== 6'd43 || bus.out_src !== 1'b0) begin
         errors++;
         $display("FAIL stall_next got d=%0d s=%b want 43 0", bus.out_data, bus.out_src);
      end
      drain();
   endtask

   task automatic test_only_b_saturation();
      logic [5:0] d;
      // 18 beats would leave a wrapping counter at 2, which is below the limit and would starve A.
      for (int i = 0; i < 18; i++) begin
         d = 6'(i + 20);
         @(negedge clk);
         drive(1'b0, 6'd0, 1'b1, d, 1'b1);
         #1;
         checks++;
         if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
            errors++;
            $display("FAIL only_b_ready%0d got a=%b b=%b want 0 1", i, bus.a_ready, bus.b_ready);
         end
         @(posedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_src !== 1'b1 || bus.out_data !== d) begin
            errors++;
            $display("FAIL only_b_beat%0d got v=%b s=%b d=%0d want 1 1 %0d", i,
                     bus.out_valid, bus.out_src, bus.out_data, d);
         end
      end
      @(negedge clk);
      drive(1'b1, 6'd33, 1'b1, 6'd60, 1'b1);
      #1;
      checks++;
      if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
         errors++;
         $display("FAIL saturate_a_grant got a=%b b=%b want 1 0", bus.a_ready, bus.b_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_src !== 1'b0 || bus.out_data !== 6'd33) begin
         errors++;
         $display("FAIL saturate_a_out got s=%b d=%0d want 0 33", bus.out_src, bus.out_data);
      end
      drain();
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      drive(1'b1, 6'd7, 1'b0, 6'd0, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 6'd7) begin
         errors++;
         $display("FAIL areset_pre got v=%b d=%0d want 1 7", bus.out_valid, bus.out_data);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 6'd0 || bus.a_ready !== 1'b0) begin
         errors++;
         $display("FAIL areset_now got v=%b d=%0d a=%b want 0 0 0", bus.out_valid, bus.out_data, bus.a_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b1, 6'd11, 1'b1, 6'd22, 1'b1);
      #1;
      checks++;
      if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
         errors++;
         $display("FAIL areset_first_grant got a=%b b=%b want 1 0", bus.a_ready, bus.b_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_src !== 1'b0 || bus.out_data !== 6'd11) begin
         errors++;
         $display("FAIL areset_first_out got s=%b d=%0d want 0 11", bus.out_src, bus.out_data);
      end
      drain();
   endtask

   task automatic test_random();
      logic [6:0] sb[$];
      logic [6:0] exp;
      int a_wait;
      int b_wait;
      a_wait = 0;
      b_wait = 0;
      for (int i = 0; i < 10000 + 4; i++) begin
         @(negedge clk);
         if (i < 10000)
            drive($urandom_range(0, 3) != 0, 6'($urandom), $urandom_range(0, 3) != 0,
                  6'($urandom), $urandom_range(0, 3) != 0);
         else
            drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
         #1;
         checks++;
         if ((bus.a_ready & bus.b_ready) !== 1'b0 ||
             ((bus.a_ready | bus.b_ready) && bus.out_valid && !bus.out_ready)) begin
            errors++;
            $display("FAIL rand_ready_rule cyc%0d got a=%b b=%b v=%b r=%b", i,
                     bus.a_ready, bus.b_ready, bus.out_valid, bus.out_ready);
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rand_extra_beat cyc%0d got s=%b d=%0d want none", i, bus.out_src, bus.out_data);
            end else begin
               exp = sb.pop_front();
               if ({bus.out_src, bus.out_data} !== exp) begin
                  errors++;
                  $display("FAIL rand_beat cyc%0d got s=%b d=%0d want s=%b d=%0d", i,
                           bus.out_src, bus.out_data, exp[6], exp[5:0]);
               end
            end
         end
         if (bus.a_valid && bus.a_ready) sb.push_back({1'b0, bus.a_data});
         if (bus.b_valid && bus.b_ready) sb.push_back({1'b1, bus.b_data});
         if (!bus.a_valid || bus.a_ready) a_wait = 0;
         else if (bus.b_ready) a_wait++;
         if (!bus.b_valid || bus.b_ready) b_wait = 0;
         else if (bus.a_ready) b_wait++;
         checks++;
         if (a_wait > MB + 1 || b_wait > MB + 1) begin
            errors++;
            $display("FAIL rand_starve cyc%0d got a_wait=%0d b_wait=%0d want <= %0d", i, a_wait, b_wait, MB + 1);
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL rand_lost_beats got %0d left want 0", sb.size());
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_a();
      test_alternation();
      test_stall();
      test_only_b_saturation();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/residue_channel_arbiter.md
RESIDUE_CHANNEL_ARBITER -- requirements
Module: residue_channel_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive grants to one requester while the other is waiting; legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 a_valid  input  1  requester A offers a residue.
REQ-005 a_data  input  6  requester A residue.
REQ-006 a_ready  output  1  A beat accepted this cycle when a_valid & a_ready.
REQ-007 b_valid  input  1  requester B offers a residue.
REQ-008 b_data  input  6  requester B residue.
REQ-009 b_ready  output  1  B beat accepted this cycle when b_valid & b_ready.
REQ-010 out_valid  output  1  registered output beat present.
REQ-011 out_data  output  6  registered selected residue.
REQ-012 out_src  output  1  source of out_data: 0 = A, 1 = B.
REQ-013 out_ready  input  1  downstream accepts the output beat when out_valid & out_ready.

Function
REQ-014 The block SHALL share one 6-bit residue channel between A and B through an internal 2:1 selection, with the select driven only by the arbiter state.
REQ-015 The output stage SHALL be a single register; it is "free" when out_valid = 0 or out_ready = 1.
REQ-016 At most one of a_ready and b_ready SHALL be high in any cycle, and neither SHALL be high unless the output stage is free.
REQ-017 Readies SHALL be combinational from state, a_valid, b_valid and out_ready; readies SHALL never depend on a_data or b_data.
REQ-018 FSM states: IDLE (no owner), OWN_A, OWN_B; encoding is free.
REQ-019 Grant rule when stage free, from IDLE: if only one requester is valid, that requester SHALL be granted; if both are valid, A SHALL be granted.
REQ-020 Grant rule from OWN_x: x SHALL be granted if x is valid and (the other is not valid or burst_cnt < MAX_BURST); otherwise the other SHALL be granted if valid; if neither is valid, the state SHALL go to IDLE.
REQ-021 burst_cnt (4 bits) SHALL load 1 on a grant that changes owner or leaves IDLE, increment on a grant to the same owner, saturate at 15, and clear in IDLE.
REQ-022 On a grant, out_data SHALL load the granted data, out_src SHALL load the granted id, and out_valid SHALL be 1 on the next cycle (latency 1 cycle).
REQ-023 On no grant with out_ready = 1, out_valid SHALL go to 0; with out_valid = 1 and out_ready = 0, out_valid, out_data and out_src SHALL hold unchanged.
REQ-024 While the stage is not free, the state and burst_cnt SHALL hold.
REQ-025 Back-to-back throughput SHALL be one beat per cycle when out_ready is held high.
REQ-026 A requester dropping valid without being granted SHALL cause no error; the arbiter SHALL re-evaluate next cycle.
REQ-027 No beat SHALL be duplicated or lost: each accepted input beat SHALL appear exactly once on the output, in acceptance order.

Reset
REQ-028 On reset_n = 0, asynchronously: state = IDLE, burst_cnt = 0, out_valid = 0, out_data = 0, out_src = 0.
REQ-029 While reset_n = 0, a_ready = 0 and b_ready = 0.
REQ-030 Deassertion of reset_n mid-transfer SHALL discard any held output beat; the first grant after reset SHALL follow the IDLE rule.

Verification
REQ-031 Only A valid, a_data = 6'd17, out_ready = 1 -> a_ready = 1 in the same cycle; out_valid = 1, out_data = 17, out_src = 0 in the next cycle.
REQ-032 Both requesters valid continuously, out_ready = 1, MAX_BURST = 4, from IDLE -> output source sequence AAAA BBBB AAAA.
REQ-033 out_valid = 1 with out_data = 6'd42, out_ready held 0 for 5 cycles -> out_data holds 42, a_ready = b_ready = 0 throughout; out_ready = 1 -> next grant issued in that same cycle.
REQ-034 Only B valid for 10 cycles with out_ready = 1 -> 10 consecutive B beats; burst_cnt saturates at 15 rather than wrapping on longer runs; an A request arriving after that is granted on the first free cycle.
REQ-035 Assert reset_n = 0 while out_valid = 1 -> out_valid = 0 immediately, with no clock edge required; after release, with both requesters valid, A is granted first.
REQ-036 Randomized valid/out_ready for 10k cycles with a scoreboard -> ready is never high for both requesters, no beat is lost or duplicated, and no requester waits more than MAX_BURST + 1 grants.
